// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage core, with trap/MRET sequencing and a stall-cycle counter.
// Latency: stall/flush outputs are combinational from ID/EX/MEM status; trap/MRET pulses follow detection by one cycle.
// Backpressure: mem_busy freezes IF..MEM and bubbles WB; load-use and CSR hazards hold IF/ID and bubble EX.
module pipeline_hazard_ctrl #(
  parameter int RF_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             id_valid,
  input  logic             id_rs1_read,
  input  logic             id_rs2_read,
  input  logic [RF_W-1:0]  id_rs1_regid,
  input  logic [RF_W-1:0]  id_rs2_regid,
  input  logic             id_csr,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [RF_W-1:0]  ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_valid,
  input  logic             mem_busy,
  input  logic             mem_exception,
  input  logic             mem_mret,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic             wb_flush,
  output logic             trap_take,
  output logic             mret_take,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_MRET = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic evt_trap;
  logic evt_mret;
  logic evt_take;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic csr_wait;
  logic redirect;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RF_W-1:0]  REG_X0  = '0;

  // Hazard and event decode from the current ID/EX/MEM status.
  always_comb begin
    // An exception outranks MRET when both are flagged on the same instruction.
    evt_trap = mem_valid & mem_exception & ~mem_busy;
    evt_mret = mem_valid & mem_mret & ~mem_busy & ~mem_exception;
    evt_take = evt_trap | evt_mret;
    redirect = ex_redirect & ex_valid;
    // x0 is hardwired zero, so a load targeting it never produces a dependency.
    rs1_hit  = id_rs1_read & (id_rs1_regid == ex_rd);
    rs2_hit  = id_rs2_read & (id_rs2_regid == ex_rd);
    load_use = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != REG_X0) &
               id_valid & (rs1_hit | rs2_hit);
    // CSR accesses wait until nothing older is left in EX or MEM.
    csr_wait = id_valid & id_csr & (ex_valid | mem_valid);
  end

  // Sequencer state register; reset always lands in RUN so a pending pulse is dropped.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and stage controls; RUN applies the hazard priority list.
  always_comb begin
    state_nxt = ST_RUN;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    wb_flush  = 1'b0;
    trap_take = 1'b0;
    mret_take = 1'b0;
    unique case (state)
      ST_TRAP: begin
        // The faulting instruction is now in WB; kill it along with everything younger.
        trap_take = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        wb_flush  = 1'b1;
      end
      ST_MRET: begin
        mret_take = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        wb_flush  = 1'b1;
      end
      default: begin
        if (evt_take) begin
          // Kill younger instructions now; the MEM instruction moves on to WB.
          id_flush  = 1'b1;
          ex_flush  = 1'b1;
          mem_flush = 1'b1;
          state_nxt = evt_trap ? ST_TRAP : ST_MRET;
        end else if (mem_busy) begin
          // Bus wait: freeze everything up to MEM, WB gets a bubble.
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_stall = 1'b1;
          wb_flush  = 1'b1;
        end else if (redirect) begin
          // Wrong-path instructions in IF->ID and ID->EX are discarded; no stall needed.
          id_flush = 1'b1;
          ex_flush = 1'b1;
        end else if (load_use | csr_wait) begin
          // Hold the ID instruction and push a bubble into EX.
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_flush = 1'b1;
        end
      end
    endcase
  end

  // Saturating count of cycles in which fetch is held.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_count <= '0;
    end else if (if_stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule
